// File: rtl/adc_frame_align.sv
// Frame-lane bitslip alignment and 16-bit sample assembly for ADC LVDS lanes.
// Ports: clk, rst_n (async low); frame_q/data_a/data_b in; bitslip, locked,
//   sample, sample_valid, slip_count, err_count out.
// Macro ADC_ALIGN_ERRCNT_EN enables err_count; otherwise it reads 8'h00.
module adc_frame_align #(
  parameter logic [7:0]  PATTERN    = 8'hF0,
  parameter int unsigned SLIP_WAIT  = 4,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned MISS_MAX   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  frame_q,
  input  logic [7:0]  data_a,
  input  logic [7:0]  data_b,
  output logic        bitslip,
  output logic        locked,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic [2:0]  slip_count,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    S_SEARCH,
    S_SLIP,
    S_WAIT,
    S_VERIFY,
    S_LOCKED
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(SLIP_WAIT - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [3:0] MISS_LAST = 4'(MISS_MAX - 1);

  state_t      state_q;
  logic [3:0]  wait_cnt_q;
  logic [7:0]  match_cnt_q;
  logic [3:0]  miss_cnt_q;
  logic        bitslip_q;
  logic        locked_q;
  logic [15:0] sample_q;
  logic        valid_q;
  logic [2:0]  slip_cnt_q;
  logic        match;

  assign match = (frame_q == PATTERN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SEARCH;
      wait_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      slip_cnt_q  <= '0;
    end else begin
      bitslip_q <= 1'b0;
      valid_q   <= 1'b0;
      unique case (state_q)
        S_SEARCH: begin
          if (match) begin
            state_q     <= S_VERIFY;
            match_cnt_q <= 8'd1;
          end else begin
            state_q    <= S_SLIP;
            bitslip_q  <= 1'b1;
            slip_cnt_q <= slip_cnt_q + 3'd1;
          end
        end
        S_SLIP: begin
          state_q    <= S_WAIT;
          wait_cnt_q <= '0;
        end
        // Deserializer output is unsettled here; frame_q is not examined.
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q <= S_SEARCH;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        S_VERIFY: begin
          if (match) begin
            match_cnt_q <= match_cnt_q + 8'd1;
            if (match_cnt_q == LOCK_LAST) begin
              state_q    <= S_LOCKED;
              locked_q   <= 1'b1;
              miss_cnt_q <= '0;
            end
          end else begin
            state_q     <= S_SLIP;
            match_cnt_q <= '0;
            bitslip_q   <= 1'b1;
            slip_cnt_q  <= slip_cnt_q + 3'd1;
          end
        end
        S_LOCKED: begin
          if (match) begin
            miss_cnt_q <= '0;
            sample_q   <= {data_a, data_b};
            valid_q    <= 1'b1;
          end else if (miss_cnt_q == MISS_LAST) begin
            // Drop back to a plain search; the search itself decides
            // whether a slip is needed.
            state_q    <= S_SEARCH;
            locked_q   <= 1'b0;
            miss_cnt_q <= '0;
          end else begin
            miss_cnt_q <= miss_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q  <= S_SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_ALIGN_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (state_q == S_LOCKED && !match
                 && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  assign bitslip      = bitslip_q;
  assign locked       = locked_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign slip_count   = slip_cnt_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// Self-checking bench for adc_frame_align against an event-level model.
// Honours ADC_ALIGN_ERRCNT_EN for the expected err_count.
module tb_adc_frame_align;

  localparam logic [7:0] PAT   = 8'hF0;
  localparam int         WAITN = 4;
  localparam int         LOCKN = 16;
  localparam int         MISSN = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  frame_q;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        bitslip;
  logic        locked;
  logic [15:0] sample;
  logic        sample_valid;
  logic [2:0]  slip_count;
  logic [7:0]  err_count;

  int checks;
  int failures;

  // Model: "blind" = edges still to ignore after a slip (slip cycle plus
  // settling window), "run" = consecutive matches while hunting.
  bit          m_locked;
  int          m_blind;
  int          m_run;
  int          m_miss;
  int          m_slips;
  int          m_err;
  bit          m_bitslip;
  bit          m_valid;
  logic [15:0] m_sample;
  logic [7:0]  e_err;
  int          rot;

  adc_frame_align dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_q      (frame_q),
    .data_a       (data_a),
    .data_b       (data_b),
    .bitslip      (bitslip),
    .locked       (locked),
    .sample       (sample),
    .sample_valid (sample_valid),
    .slip_count   (slip_count),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n % 8; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic model_reset();
    m_locked  = 0;
    m_blind   = 0;
    m_run     = 0;
    m_miss    = 0;
    m_slips   = 0;
    m_err     = 0;
    m_bitslip = 0;
    m_valid   = 0;
    m_sample  = 16'h0000;
    e_err     = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    frame_q = 8'h00;
    data_a  = 8'h00;
    data_b  = 8'h00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model across the edge and
  // leave time 1 unit past the edge for sampling.
  task automatic tick(input logic [7:0] fr, input logic [7:0] a,
                      input logic [7:0] b);
    bit m;
    frame_q = fr;
    data_a  = a;
    data_b  = b;
    @(posedge clk);
    m = (fr == PAT);
    m_bitslip = 0;
    m_valid   = 0;
    if (m_locked) begin
      if (m) begin
        m_miss   = 0;
        m_sample = {a, b};
        m_valid  = 1;
      end else begin
        if (m_err < 255) m_err++;
        m_miss++;
        if (m_miss == MISSN) begin
          m_locked = 0;
          m_miss   = 0;
          m_run    = 0;
        end
      end
    end else if (m_blind > 0) begin
      m_blind--;
    end else if (m) begin
      m_run++;
      if (m_run == LOCKN) begin
        m_locked = 1;
        m_run    = 0;
      end
    end else begin
      m_bitslip = 1;
      m_slips++;
      m_blind = WAITN + 1;
      m_run   = 0;
    end
`ifdef ADC_ALIGN_ERRCNT_EN
    e_err = 8'(m_err);
`else
    e_err = 8'h00;
`endif
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_q = 8'h00;
    data_a = 8'h00;
    data_b = 8'h00;
    model_reset();
    #12;
    checks++;
    if ({bitslip, locked, sample_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000",
               {bitslip, locked, sample_valid});
    end
    checks++;
    if (sample !== 16'h0000 || slip_count !== 3'd0 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_values sample=%h slip=%0d err=%0d exp 0",
               sample, slip_count, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aligned();
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tick(PAT, 8'h12, 8'h34);
      checks++;
      if (bitslip !== m_bitslip || locked !== m_locked
          || sample_valid !== m_valid) begin
        failures++;
        $display("FAIL aligned_cyc%0d bs/lk/v got=%b%b%b exp=%b%b%b", c,
                 bitslip, locked, sample_valid, m_bitslip, m_locked, m_valid);
      end
      if (c == 15) begin
        checks++;
        if (locked !== 1'b0) begin
          failures++;
          $display("FAIL aligned_early_lock got=%b exp=0", locked);
        end
      end
      if (c == 16) begin
        checks++;
        if (locked !== 1'b1 || sample_valid !== 1'b0) begin
          failures++;
          $display("FAIL aligned_lock16 lk=%b v=%b exp lk=1 v=0",
                   locked, sample_valid);
        end
      end
      if (c == 17) begin
        checks++;
        if (sample_valid !== 1'b1 || sample !== 16'h1234) begin
          failures++;
          $display("FAIL aligned_first_sample v=%b s=%h exp v=1 s=1234",
                   sample_valid, sample);
        end
      end
    end
    checks++;
    if (slip_count !== 3'd0) begin
      failures++;
      $display("FAIL aligned_no_slip got=%0d exp=0", slip_count);
    end
  endtask

  task automatic test_slip_search();
    int pulses;
    int last;
    do_reset();
    rot = 0;
    pulses = 0;
    last = -100;
    for (int c = 0; c < 60; c++) begin
      tick(rotl(8'h1E, rot), 8'h00, 8'h00);
      checks++;
      if (bitslip !== m_bitslip || locked !== m_locked
          || slip_count !== 3'(m_slips)) begin
        failures++;
        $display("FAIL slip_cyc%0d bs=%b lk=%b sc=%0d exp bs=%b lk=%b sc=%0d",
                 c, bitslip, locked, slip_count, m_bitslip, m_locked,
                 m_slips % 8);
      end
      if (bitslip === 1'b1) begin
        checks++;
        if (c - last < WAITN + 2) begin
          failures++;
          $display("FAIL slip_spacing got=%0d exp>=%0d", c - last, WAITN + 2);
        end
        last = c;
        pulses++;
      end
      if (m_bitslip) rot++;
    end
    checks++;
    if (pulses != 3 || slip_count !== 3'd3 || locked !== 1'b1) begin
      failures++;
      $display("FAIL slip_total pulses=%0d sc=%0d lk=%b exp 3/3/1",
               pulses, slip_count, locked);
    end
  endtask

  task automatic test_locked_miss();
    do_reset();
    for (int c = 0; c < LOCKN + 1; c++) tick(PAT, 8'hA5, 8'h5A);
    tick(8'h00, 8'h11, 8'h22);
    checks++;
    if (sample_valid !== 1'b0 || locked !== 1'b1 || bitslip !== 1'b0
        || sample !== 16'hA55A) begin
      failures++;
      $display("FAIL miss1 v=%b lk=%b bs=%b s=%h exp 0/1/0/a55a",
               sample_valid, locked, bitslip, sample);
    end
    checks++;
    if (err_count !== e_err) begin
      failures++;
      $display("FAIL miss1_err got=%0d exp=%0d", err_count, e_err);
    end
    tick(PAT, 8'h77, 8'h88);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 16'h7788 || locked !== 1'b1) begin
      failures++;
      $display("FAIL miss1_recover v=%b s=%h lk=%b", sample_valid, sample,
               locked);
    end
    tick(8'h0F, 8'h00, 8'h00);
    checks++;
    if (locked !== 1'b1 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss2a lk=%b v=%b exp 1/0", locked, sample_valid);
    end
    tick(8'hE1, 8'h00, 8'h00);
    checks++;
    if (locked !== 1'b0 || bitslip !== 1'b0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss2b lk=%b bs=%b v=%b exp 0/0/0", locked, bitslip,
               sample_valid);
    end
    checks++;
    if (err_count !== e_err) begin
      failures++;
      $display("FAIL miss2_err got=%0d exp=%0d", err_count, e_err);
    end
    tick(PAT, 8'h00, 8'h00);
    checks++;
    if (bitslip !== 1'b0 || slip_count !== 3'd0 || locked !== 1'b0) begin
      failures++;
      $display("FAIL miss_exit_noslip bs=%b sc=%0d lk=%b", bitslip,
               slip_count, locked);
    end
  endtask

  task automatic test_verify_miss();
    int lock_at;
    do_reset();
    lock_at = -1;
    for (int c = 1; c <= 9; c++) tick(PAT, 8'h00, 8'h00);
    tick(8'h00, 8'h00, 8'h00);
    checks++;
    if (bitslip !== 1'b1 || slip_count !== 3'd1) begin
      failures++;
      $display("FAIL verify_miss bs=%b sc=%0d exp 1/1", bitslip, slip_count);
    end
    for (int c = 1; c <= 30; c++) begin
      tick(PAT, 8'h00, 8'h00);
      if (locked === 1'b1 && lock_at < 0) lock_at = c;
    end
    checks++;
    if (lock_at != WAITN + 1 + LOCKN) begin
      failures++;
      $display("FAIL verify_relock got=%0d exp=%0d", lock_at,
               WAITN + 1 + LOCKN);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < LOCKN + 3; c++) tick(PAT, 8'hC3, 8'h3C);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bitslip, locked, sample_valid} !== 3'b000 || sample !== 16'h0
        || slip_count !== 3'd0 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL async_rst bs=%b lk=%b v=%b s=%h sc=%0d err=%0d",
               bitslip, locked, sample_valid, sample, slip_count, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LOCKN; c++) tick(PAT, 8'h01, 8'h02);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL async_relock got=%b exp=1", locked);
    end
    tick(PAT, 8'h03, 8'h04);
    checks++;
    if (sample_valid !== 1'b1 || sample !== 16'h0304) begin
      failures++;
      $display("FAIL async_sample v=%b s=%h exp 1/0304", sample_valid, sample);
    end
    do_reset();
    tick(8'h00, 8'h00, 8'h00);
    checks++;
    if (bitslip !== 1'b1) begin
      failures++;
      $display("FAIL pulse_pre got=%b exp=1", bitslip);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bitslip !== 1'b0 || slip_count !== 3'd0) begin
      failures++;
      $display("FAIL pulse_rst bs=%b sc=%0d exp 0/0", bitslip, slip_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_errcnt();
    logic [7:0] a;
    logic [7:0] b;
    do_reset();
    for (int c = 0; c < LOCKN; c++) tick(PAT, 8'h00, 8'h00);
    for (int i = 0; i < 300; i++) begin
      tick(8'h00, 8'h00, 8'h00);
      a = 8'($urandom);
      b = 8'($urandom);
      tick(PAT, a, b);
      checks++;
      if (sample !== m_sample || sample_valid !== 1'b1
          || err_count !== e_err) begin
        failures++;
        $display("FAIL err_iter%0d s=%h v=%b err=%0d exp s=%h v=1 err=%0d",
                 i, sample, sample_valid, err_count, m_sample, e_err);
      end
    end
`ifdef ADC_ALIGN_ERRCNT_EN
    e_err = 8'hFF;
`else
    e_err = 8'h00;
`endif
    checks++;
    if (err_count !== e_err || locked !== 1'b1) begin
      failures++;
      $display("FAIL err_final err=%0d lk=%b exp err=%0d lk=1", err_count,
               locked, e_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] fr;
    do_reset();
    rot = $urandom_range(0, 7);
    for (int c = 0; c < 600; c++) begin
      fr = rotl(PAT, rot);
      if ($urandom_range(0, 11) == 0) fr = 8'($urandom);
      tick(fr, 8'($urandom), 8'($urandom));
      checks++;
      if (bitslip !== m_bitslip || locked !== m_locked
          || sample_valid !== m_valid || sample !== m_sample
          || slip_count !== 3'(m_slips) || err_count !== e_err) begin
        failures++;
        $display("FAIL rand_cyc%0d bs=%b lk=%b v=%b s=%h sc=%0d err=%0d exp %b %b %b %h %0d %0d",
                 c, bitslip, locked, sample_valid, sample, slip_count,
                 err_count, m_bitslip, m_locked, m_valid, m_sample,
                 m_slips % 8, e_err);
      end
      if (m_bitslip) rot++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_aligned();
    test_slip_search();
    test_locked_miss();
    test_verify_miss();
    test_async_reset();
    test_errcnt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
